// File: rtl/eth_pkg.sv
// Shared Ethernet constants, framer state encoding and a counter-width helper
// for the TX framer and the CRC-32 logic.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE        = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE             = 8'hD5;
    localparam logic [31:0] ETH_CRC32_POLY_REFLECTED = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC32_INIT           = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        PAD,
        FCS,
        GAP
    } framer_state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected IEEE 802.3 CRC-32 (LSB first). Pure
// combinational so the RX FCS checker can reuse it unchanged.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0]) begin
                crc_out = {1'b0, crc_out[31:1]} ^ ETH_CRC32_POLY_REFLECTED;
            end else begin
                crc_out = {1'b0, crc_out[31:1]};
            end
        end
    end

endmodule

// File: rtl/axis_eth_tx_framer.sv
// Wraps a raw MAC frame stream with preamble/SFD, minimum-length zero padding,
// the FCS and an inter-frame gap, ready to feed the RMII transmitter.
module axis_eth_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES  = 7,
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned IFG_CYCLES      = 48
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] saxis_tdata,
    input  logic       saxis_tvalid,
    output logic       saxis_tready,
    input  logic       saxis_tlast,
    output logic [7:0] maxis_tdata,
    output logic       maxis_tvalid,
    input  logic       maxis_tready,
    output logic       maxis_tlast
);

    localparam int unsigned PRE_W = cnt_width(PREAMBLE_BYTES);
    localparam int unsigned CNT_W = cnt_width(MIN_FRAME_BYTES);
    localparam int unsigned GAP_W = cnt_width(IFG_CYCLES);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_BYTES);
    localparam logic [CNT_W:0]   MIN_CNT  = (CNT_W + 1)'(MIN_FRAME_BYTES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    framer_state_t    state_reg;
    logic [31:0]      crc_reg;
    logic [CNT_W-1:0] byte_cnt_reg;
    logic [PRE_W-1:0] pre_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [1:0]       fcs_idx_reg;
    logic [7:0]       tdata_reg;
    logic             tvalid_reg;
    logic             tlast_reg;

    logic [7:0]       crc_data;
    logic [31:0]      crc_next;
    logic [CNT_W:0]   cnt_inc;
    logic [PRE_W-1:0] pre_next;
    logic [1:0]       fcs_idx_next;
    logic [31:0]      fcs_word;
    logic [7:0]       fcs_byte;
    logic             out_hs;

    // Payload is a zero-latency passthrough; every other state drives registers.
    assign maxis_tdata  = (state_reg == PAYLOAD) ? saxis_tdata  : tdata_reg;
    assign maxis_tvalid = (state_reg == PAYLOAD) ? saxis_tvalid : tvalid_reg;
    assign maxis_tlast  = tlast_reg;
    assign saxis_tready = (state_reg == PAYLOAD) ? maxis_tready : 1'b0;

    assign out_hs       = maxis_tvalid && maxis_tready;
    assign crc_data     = (state_reg == PAYLOAD) ? saxis_tdata : 8'h00;
    assign cnt_inc      = {1'b0, byte_cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
    assign pre_next     = pre_cnt_reg + {{(PRE_W - 1){1'b0}}, 1'b1};
    assign fcs_idx_next = fcs_idx_reg + 2'd1;
    assign fcs_word     = ~crc_reg;

    always_comb begin
        fcs_byte = fcs_word[7:0];
        case (fcs_idx_next)
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            2'd3:    fcs_byte = fcs_word[31:24];
            default: fcs_byte = fcs_word[7:0];
        endcase
    end

    eth_crc32_byte u_crc (
        .crc_in  (crc_reg),
        .data    (crc_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            crc_reg      <= ETH_CRC32_INIT;
            byte_cnt_reg <= '0;
            pre_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            fcs_idx_reg  <= 2'd0;
            tdata_reg    <= 8'h00;
            tvalid_reg   <= 1'b0;
            tlast_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (saxis_tvalid) begin
                        state_reg    <= PREAMBLE;
                        crc_reg      <= ETH_CRC32_INIT;
                        byte_cnt_reg <= '0;
                        pre_cnt_reg  <= '0;
                        tvalid_reg   <= 1'b1;
                        tdata_reg    <= (PREAMBLE_BYTES == 0) ? ETH_SFD_BYTE : ETH_PREAMBLE_BYTE;
                    end
                end

                PREAMBLE: begin
                    if (out_hs) begin
                        if (pre_cnt_reg == PRE_LAST) begin
                            state_reg   <= PAYLOAD;
                            pre_cnt_reg <= '0;
                            tvalid_reg  <= 1'b0;
                            tdata_reg   <= 8'h00;
                        end else begin
                            pre_cnt_reg <= pre_next;
                            tdata_reg   <= (pre_next == PRE_LAST) ? ETH_SFD_BYTE : ETH_PREAMBLE_BYTE;
                        end
                    end
                end

                PAYLOAD: begin
                    if (out_hs) begin
                        crc_reg <= crc_next;
                        if ({1'b0, byte_cnt_reg} < MIN_CNT) begin
                            byte_cnt_reg <= cnt_inc[CNT_W-1:0];
                        end
                        if (saxis_tlast) begin
                            tvalid_reg <= 1'b1;
                            if (cnt_inc < MIN_CNT) begin
                                state_reg <= PAD;
                                tdata_reg <= 8'h00;
                            end else begin
                                state_reg   <= FCS;
                                fcs_idx_reg <= 2'd0;
                                tdata_reg   <= ~crc_next[7:0];
                            end
                        end
                    end
                end

                PAD: begin
                    if (out_hs) begin
                        crc_reg      <= crc_next;
                        byte_cnt_reg <= cnt_inc[CNT_W-1:0];
                        if (cnt_inc == MIN_CNT) begin
                            state_reg   <= FCS;
                            fcs_idx_reg <= 2'd0;
                            tdata_reg   <= ~crc_next[7:0];
                        end
                    end
                end

                FCS: begin
                    if (out_hs) begin
                        if (fcs_idx_reg == 2'd3) begin
                            state_reg   <= (IFG_CYCLES == 0) ? IDLE : GAP;
                            fcs_idx_reg <= 2'd0;
                            gap_cnt_reg <= '0;
                            tvalid_reg  <= 1'b0;
                            tlast_reg   <= 1'b0;
                            tdata_reg   <= 8'h00;
                        end else begin
                            fcs_idx_reg <= fcs_idx_next;
                            tdata_reg   <= fcs_byte;
                            tlast_reg   <= (fcs_idx_next == 2'd3);
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg   <= IDLE;
                        gap_cnt_reg <= '0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + {{(GAP_W - 1){1'b0}}, 1'b1};
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_eth_tx_framer.sv
// Bench for the TX framer: a frame-level reference builds the expected wire
// bytes, and a per-cycle monitor compares every output handshake against it.
module tb_axis_eth_tx_framer;

    localparam int IFG = 48;

    typedef logic [8:0] beat_t;
    typedef logic [7:0] bytes_t[$];

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] s_tdata, z_s_tdata;
    logic       s_tvalid, z_s_tvalid, s_tlast, z_s_tlast;
    logic       s_tready, z_s_tready;
    logic [7:0] m_tdata, z_m_tdata;
    logic       m_tvalid, z_m_tvalid, m_tlast, z_m_tlast;
    logic       m_tready, z_m_tready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int gap_meas = -1;
    bit gap_arm = 0;
    bit rand_mode = 0;
    bit prev_stall = 0;
    beat_t prev_beat;

    beat_t exp_a[$], exp_z[$], cap_a[$], cap_z[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    axis_eth_tx_framer dut (
        .clock(clock), .reset(reset),
        .saxis_tdata(s_tdata), .saxis_tvalid(s_tvalid), .saxis_tready(s_tready), .saxis_tlast(s_tlast),
        .maxis_tdata(m_tdata), .maxis_tvalid(m_tvalid), .maxis_tready(m_tready), .maxis_tlast(m_tlast)
    );

    axis_eth_tx_framer #(.MIN_FRAME_BYTES(0)) dut_z (
        .clock(clock), .reset(reset),
        .saxis_tdata(z_s_tdata), .saxis_tvalid(z_s_tvalid), .saxis_tready(z_s_tready), .saxis_tlast(z_s_tlast),
        .maxis_tdata(z_m_tdata), .maxis_tvalid(z_m_tvalid), .maxis_tready(z_m_tready), .maxis_tlast(z_m_tlast)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                logic fb = c[0] ^ q[i][b];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    function automatic bytes_t mk_payload(input int n, input int seed);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'((seed + i * 37) & 8'hFF));
        return q;
    endfunction

    // Expected wire image: preamble, SFD, payload, zero pad, FCS LSB first.
    task automatic model_frame(input bit z, input logic [7:0] pl[$], input int minb);
        logic [7:0] fr[$];
        logic [31:0] f;
        beat_t bq[$];
        fr = pl;
        while (fr.size() < minb) fr.push_back(8'h00);
        f = crc32(fr);
        for (int i = 0; i < 7; i++) bq.push_back({1'b0, 8'h55});
        bq.push_back({1'b0, 8'hD5});
        foreach (fr[i]) bq.push_back({1'b0, fr[i]});
        for (int k = 0; k < 4; k++) bq.push_back({k == 3, f[8*k +: 8]});
        foreach (bq[i]) begin
            if (z) exp_z.push_back(bq[i]);
            else exp_a.push_back(bq[i]);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) chk("hold", {23'd0, m_tvalid, m_tlast, m_tdata}, {23'd0, 1'b1, prev_beat});
            prev_stall = m_tvalid && !m_tready;
            prev_beat = {m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                cap_a.push_back({m_tlast, m_tdata});
                if (exp_a.size() == 0) chk("unexpected_beat", {23'd0, m_tlast, m_tdata}, 32'hFFFFFFFF);
                else chk("beat", {23'd0, m_tlast, m_tdata}, {23'd0, exp_a.pop_front()});
            end
            if (m_tvalid && m_tready && m_tlast) begin
                last_cyc = cyc;
                gap_arm = 1;
            end else if (gap_arm && m_tvalid) begin
                gap_meas = cyc - last_cyc - 1;
                gap_arm = 0;
            end
            if (z_m_tvalid && z_m_tready) begin
                cap_z.push_back({z_m_tlast, z_m_tdata});
                if (exp_z.size() == 0) chk("unexpected_beat_z", {23'd0, z_m_tlast, z_m_tdata}, 32'hFFFFFFFF);
                else chk("beat_z", {23'd0, z_m_tlast, z_m_tdata}, {23'd0, exp_z.pop_front()});
            end
        end
    end

    always @(posedge clock) begin
        if (rand_mode) begin
            #1;
            m_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic drive(input bit z, input logic [7:0] d, input logic v, input logic l);
        if (z) begin
            z_s_tdata = d; z_s_tvalid = v; z_s_tlast = l;
        end else begin
            s_tdata = d; s_tvalid = v; s_tlast = l;
        end
    endtask

    task automatic push_byte(input bit z, input logic [7:0] d, input logic l);
        bit hs;
        int guard = 0;
        drive(z, d, 1'b1, l);
        forever begin
            @(negedge clock);
            hs = z ? (z_s_tready && z_s_tvalid) : (s_tready && s_tvalid);
            @(posedge clock);
            #1;
            if (hs) break;
            guard++;
            if (guard > 3000) begin
                chk("push_timeout", 32'(guard), 32'd0);
                break;
            end
        end
    endtask

    task automatic send_frame(input bit z, input logic [7:0] pl[$], input bit hold,
                              input int stall_at, input int rst_at);
        for (int i = 0; i < pl.size(); i++) begin
            if (i == rst_at) begin
                drive(z, pl[i], 1'b1, 1'b0);
                reset = 1'b1;
                repeat (3) begin
                    @(negedge clock);
                    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
                    chk("rst_tready", {31'd0, s_tready}, 32'd0);
                    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
                    @(posedge clock);
                    #1;
                end
                drive(z, 8'h00, 1'b0, 1'b0);
                reset = 1'b0;
                return;
            end
            push_byte(z, pl[i], i == pl.size() - 1);
            if (i == stall_at) begin
                drive(z, 8'h00, 1'b0, 1'b0);
                repeat (3) begin
                    @(negedge clock);
                    chk("stall_tvalid", {31'd0, m_tvalid}, 32'd0);
                    @(posedge clock);
                    #1;
                end
            end
        end
        if (!hold) drive(z, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input bit z);
        int guard = 0;
        while ((z ? exp_z.size() : exp_a.size()) != 0 && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        chk("drain_timeout", 32'(z ? exp_z.size() : exp_a.size()), 32'd0);
        repeat (IFG + 4) @(posedge clock);
        #1;
    endtask

    initial begin
        bytes_t pl, pl2;
        reset = 1'b1;
        drive(0, 8'h00, 1'b0, 1'b0);
        drive(1, 8'h00, 1'b0, 1'b0);
        m_tready = 1'b1;
        z_m_tready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("reset_tdata", {24'd0, m_tdata}, 32'd0);
        chk("reset_tlast", {31'd0, m_tlast}, 32'd0);
        chk("reset_tready", {31'd0, s_tready}, 32'd0);
        chk("reset_tvalid_z", {31'd0, z_m_tvalid}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // "123456789" through the unpadded instance.
        pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_crc", crc32(pl), 32'hCBF43926);
        cap_z.delete();
        model_frame(1, pl, 0);
        send_frame(1, pl, 0, -1, -1);
        wait_drain(1);
        chk("z_beats", 32'(cap_z.size()), 32'd21);
        if (cap_z.size() == 21) begin
            chk("z_fcs0", {23'd0, cap_z[17]}, {23'd0, 1'b0, 8'h26});
            chk("z_fcs1", {23'd0, cap_z[18]}, {23'd0, 1'b0, 8'h39});
            chk("z_fcs2", {23'd0, cap_z[19]}, {23'd0, 1'b0, 8'hF4});
            chk("z_fcs3", {23'd0, cap_z[20]}, {23'd0, 1'b1, 8'hCB});
            chk("z_sfd", {23'd0, cap_z[7]}, {23'd0, 1'b0, 8'hD5});
        end

        // 14-byte payload padded to 60; also checks one-cycle start latency.
        pl = mk_payload(14, 3);
        cap_a.delete();
        model_frame(0, pl, 60);
        drive(0, pl[0], 1'b1, 1'b0);
        @(negedge clock);
        chk("latency_idle", {31'd0, m_tvalid}, 32'd0);
        @(negedge clock);
        chk("latency_first", {23'd0, m_tvalid, m_tdata}, {23'd0, 1'b1, 8'h55});
        @(posedge clock);
        #1;
        send_frame(0, pl, 0, -1, -1);
        wait_drain(0);
        chk("pad_beats", 32'(cap_a.size()), 32'd72);
        if (cap_a.size() == 72) begin
            chk("pad_last_data", {23'd0, cap_a[21]}, {23'd0, 1'b0, pl[13]});
            chk("pad_first_zero", {23'd0, cap_a[22]}, 32'd0);
            chk("pad_last_zero", {23'd0, cap_a[67]}, 32'd0);
        end

        // 100-byte payload under random backpressure.
        pl = mk_payload(100, 11);
        cap_a.delete();
        model_frame(0, pl, 60);
        rand_mode = 1;
        send_frame(0, pl, 0, -1, -1);
        begin
            int guard = 0;
            while (exp_a.size() != 0 && guard < 5000) begin
                @(negedge clock);
                guard++;
            end
        end
        rand_mode = 0;
        @(posedge clock);
        #2;
        m_tready = 1'b1;
        wait_drain(0);
        chk("long_beats", 32'(cap_a.size()), 32'd112);

        // Back-to-back frames with input valid held high.
        pl = mk_payload(10, 21);
        pl2 = mk_payload(20, 77);
        gap_meas = -1;
        model_frame(0, pl, 60);
        model_frame(0, pl2, 60);
        send_frame(0, pl, 1, -1, -1);
        send_frame(0, pl2, 0, -1, -1);
        wait_drain(0);
        chk("b2b_gap", 32'(gap_meas), 32'(IFG + 1));

        // Upstream stall of 3 cycles after payload byte 5.
        pl = mk_payload(20, 5);
        cap_a.delete();
        model_frame(0, pl, 60);
        send_frame(0, pl, 0, 4, -1);
        wait_drain(0);
        chk("stall_beats", 32'(cap_a.size()), 32'd72);

        // Reset during payload byte 20, then a clean frame.
        pl = mk_payload(40, 9);
        model_frame(0, pl, 60);
        send_frame(0, pl, 0, -1, 19);
        exp_a.delete();
        repeat (2) @(posedge clock);
        #1;
        pl = mk_payload(16, 200);
        cap_a.delete();
        model_frame(0, pl, 60);
        send_frame(0, pl, 0, -1, -1);
        wait_drain(0);
        chk("post_rst_beats", 32'(cap_a.size()), 32'd72);
        if (cap_a.size() > 0) chk("post_rst_first", {23'd0, cap_a[0]}, {23'd0, 1'b0, 8'h55});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
